// File: rtl/aes_round_engine_iter_if.sv
// Block-level handshake and key-store bus for the iterative AES round engine.
interface aes_round_engine_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_round_engine_iter.sv
// Iterative AES round engine: one reusable round datapath runs all NR rounds of a
// 128-bit block, fetching round keys by index from an external key store.
//
// state | meaning
// IDLE  | ready for a block; initial AddRoundKey applied on accept
// ROUND | one full round per cycle, counter cnt = 1 .. NR-1
// LAST  | final round without (Inv)MixColumns, result captured
// DONE  | result held on out_data until out_ready
module aes_round_engine_iter #(
  parameter int NR      = 10,
  parameter bit DECRYPT = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  aes_round_engine_iter_if.slave bus
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_round_engine_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic [3:0]   rk_idx_c;
  logic [127:0] sub_sh;
  logic [127:0] round_out;
  logic [127:0] last_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rev_aes_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // One column mixer; row 0 of the column sits in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      if (DECRYPT)
        res[31-8*i -: 8] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b) ^
                           gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
      else
        res[31-8*i -: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^
                           a[(i+2)%4] ^ a[(i+3)%4];
    end
    return res;
  endfunction

  // Byte substitution fused with the row rotation; the two commute, so one pass serves both directions.
  always_comb begin
    sub_sh = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (DECRYPT)
          sub_sh[127-8*(4*c+r) -: 8] = rev_aes_sbox(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
        else
          sub_sh[127-8*(4*c+r) -: 8] = aes_sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  // Key addition and column mixing; the inverse round adds the key before InvMixColumns.
  always_comb begin
    last_out  = sub_sh ^ bus.rk_data;
    round_out = '0;
    for (int c = 0; c < 4; c++) begin
      if (DECRYPT)
        round_out[127-32*c -: 32] = mix_col(last_out[127-32*c -: 32]);
      else
        round_out[127-32*c -: 32] = mix_col(sub_sh[127-32*c -: 32]) ^ bus.rk_data[127-32*c -: 32];
    end
  end

  // Round-key index requested from the key store, decoded from state and counter.
  always_comb begin
    rk_idx_c = 4'd0;
    case (state)
      IDLE:    rk_idx_c = DECRYPT ? NR4 : 4'd0;
      ROUND:   rk_idx_c = DECRYPT ? (NR4 - cnt) : cnt;
      LAST:    rk_idx_c = DECRYPT ? 4'd0 : NR4;
      default: rk_idx_c = 4'd0;
    endcase
  end

  // Sequencer and state register; out_data is captured once and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      st          <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st    <= bus.in_data ^ bus.rk_data;
            cnt   <= 4'd1;
            state <= ROUND;
          end
        end
        ROUND: begin
          st  <= round_out;
          cnt <= cnt + 4'd1;
          if (cnt == NR4 - 4'd1) state <= LAST;
        end
        LAST: begin
          st          <= last_out;
          out_data_q  <= last_out;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == ROUND) || (state == LAST);
  assign bus.rk_idx    = rk_idx_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
